// File: rtl/fld_pkg.sv
// Shared types for the feedback-clock frequency lock detector: lock FSM states and window classification.
// Pure package; no latency, no flow control.
package fld_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_HOLD
  } fld_state_t;

  function automatic logic fld_window_good(input int count, input int expected, input int tol);
    int diff;
    diff = count - expected;
    if (diff < 0) diff = -diff;
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/fld_window_meter.sv
// Counts fb rising edges per 2^WINDOW_LOG2-cycle window; results register on the closing edge, meas_valid one cycle later.
// No backpressure: results simply overwrite; en=0 restarts the window and holds the last results.
module fld_window_meter #(
  parameter int WINDOW_LOG2 = 8,
  parameter int EXPECTED    = 25
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic                          i_fb,
  output logic                          o_close,
  output logic [WINDOW_LOG2-1:0]        o_count,
  output logic [WINDOW_LOG2-1:0]        o_edge_count,
  output logic signed [WINDOW_LOG2:0]   o_freq_err,
  output logic                          o_meas_valid
);

  localparam logic [WINDOW_LOG2-1:0] W_MAX = '1;
  localparam logic [WINDOW_LOG2:0]   W_EXP = EXPECTED[WINDOW_LOG2:0];

  logic                        r_fb_q;
  logic [WINDOW_LOG2-1:0]      r_wc;
  logic [WINDOW_LOG2-1:0]      r_acc;
  logic [WINDOW_LOG2-1:0]      r_edge_count;
  logic signed [WINDOW_LOG2:0] r_freq_err;
  logic                        r_meas_valid;

  logic                        w_rise;
  logic [WINDOW_LOG2:0]        w_sum;
  logic [WINDOW_LOG2-1:0]      w_count;
  logic                        w_close;

  assign w_rise  = i_fb & ~r_fb_q;
  assign w_sum   = {1'b0, r_acc} + {{WINDOW_LOG2{1'b0}}, w_rise};
  // A rise on the closing cycle belongs to the closing window, so the
  // reported count is the accumulator plus the current rise, saturated.
  assign w_count = w_sum[WINDOW_LOG2] ? W_MAX : w_sum[WINDOW_LOG2-1:0];
  assign w_close = i_en && (r_wc == W_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fb_q       <= 1'b0;
      r_wc         <= '0;
      r_acc        <= '0;
      r_edge_count <= '0;
      r_freq_err   <= '0;
      r_meas_valid <= 1'b0;
    end else begin
      r_fb_q       <= i_fb;
      r_meas_valid <= w_close;
      if (!i_en) begin
        r_wc  <= '0;
        r_acc <= '0;
      end else begin
        r_wc <= r_wc + 1'b1;
        if (w_close) begin
          r_acc        <= '0;
          r_edge_count <= w_count;
          r_freq_err   <= $signed({1'b0, w_count} - W_EXP);
        end else begin
          r_acc <= w_count;
        end
      end
    end
  end

  assign o_close      = w_close;
  assign o_count      = w_count;
  assign o_edge_count = r_edge_count;
  assign o_freq_err   = r_freq_err;
  assign o_meas_valid = r_meas_valid;

endmodule

// File: rtl/fb_freq_lock_detector.sv
// Frequency lock detector for the PLL feedback divider output; lock status changes in the cycle meas_valid is high.
// No backpressure. Define FB_INPUT_SYNC_EN to insert a 2-flop synchroniser on fb_in (+2 clk edge latency).
module fb_freq_lock_detector
  import fld_pkg::*;
#(
  parameter int WINDOW_LOG2  = 8,
  parameter int EXPECTED     = 25,
  parameter int TOL          = 1,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        fb_in,
  output logic [WINDOW_LOG2-1:0]      edge_count,
  output logic signed [WINDOW_LOG2:0] freq_err,
  output logic                        meas_valid,
  output logic                        locked
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [GW:0] LC = LOCK_COUNT[GW:0];
  localparam logic [BW:0] UC = UNLOCK_COUNT[BW:0];

  logic w_fb_s;

`ifdef FB_INPUT_SYNC_EN
  logic r_sync1, r_sync2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= fb_in;
      r_sync2 <= r_sync1;
    end
  end
  assign w_fb_s = r_sync2;
`else
  assign w_fb_s = fb_in;
`endif

  logic                   w_close;
  logic [WINDOW_LOG2-1:0] w_count;

  fld_window_meter #(
    .WINDOW_LOG2 (WINDOW_LOG2),
    .EXPECTED    (EXPECTED)
  ) u_meter (
    .clk          (clk),
    .rst          (rst),
    .i_en         (en),
    .i_fb         (w_fb_s),
    .o_close      (w_close),
    .o_count      (w_count),
    .o_edge_count (edge_count),
    .o_freq_err   (freq_err),
    .o_meas_valid (meas_valid)
  );

  fld_state_t    r_state, w_state_n;
  logic [GW-1:0] r_good_cnt, w_good_n;
  logic [BW-1:0] r_bad_cnt, w_bad_n;
  logic [GW:0]   w_good_inc;
  logic [BW:0]   w_bad_inc;
  logic          w_good;
  logic          w_locked;

  assign w_good     = fld_window_good(int'(w_count), EXPECTED, TOL);
  assign w_good_inc = {1'b0, r_good_cnt} + {{GW{1'b0}}, 1'b1};
  assign w_bad_inc  = {1'b0, r_bad_cnt} + {{BW{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_UNLOCKED;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_good_cnt <= w_good_n;
      r_bad_cnt  <= w_bad_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_good_n  = r_good_cnt;
    w_bad_n   = r_bad_cnt;
    w_locked  = (r_state == ST_LOCKED) || (r_state == ST_HOLD);
    if (!en) begin
      w_state_n = ST_UNLOCKED;
      w_good_n  = '0;
      w_bad_n   = '0;
    end else if (w_close) begin
      // Counters only ever hold values below their thresholds, so GW/BW bits suffice.
      case (r_state)
        ST_UNLOCKED: begin
          if (w_good) begin
            if (LOCK_COUNT == 1) begin
              w_state_n = ST_LOCKED;
              w_good_n  = '0;
            end else begin
              w_state_n = ST_ACQUIRE;
              w_good_n  = w_good_inc[GW-1:0];
            end
          end
        end
        ST_ACQUIRE: begin
          if (!w_good) begin
            w_state_n = ST_UNLOCKED;
            w_good_n  = '0;
          end else if (w_good_inc >= LC) begin
            w_state_n = ST_LOCKED;
            w_good_n  = '0;
          end else begin
            w_good_n = w_good_inc[GW-1:0];
          end
        end
        ST_LOCKED: begin
          if (!w_good) begin
            if (UNLOCK_COUNT == 1) begin
              w_state_n = ST_UNLOCKED;
              w_bad_n   = '0;
            end else begin
              w_state_n = ST_HOLD;
              w_bad_n   = w_bad_inc[BW-1:0];
            end
          end
        end
        ST_HOLD: begin
          if (w_good) begin
            w_state_n = ST_LOCKED;
            w_bad_n   = '0;
          end else if (w_bad_inc >= UC) begin
            w_state_n = ST_UNLOCKED;
            w_bad_n   = '0;
          end else begin
            w_bad_n = w_bad_inc[BW-1:0];
          end
        end
        default: begin
          w_state_n = ST_UNLOCKED;
          w_good_n  = '0;
          w_bad_n   = '0;
        end
      endcase
    end
  end

  assign locked = w_locked;

endmodule

// File: tb/tb_fb_freq_lock_detector.sv
// Directed bench for fb_freq_lock_detector (default build): fb patterns are phase-aligned to each window
// so every window's edge count is known exactly.
module tb_fb_freq_lock_detector;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              fb_in;
  logic [7:0]        edge_count;
  logic signed [8:0] freq_err;
  logic              meas_valid;
  logic              locked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_freq_lock_detector dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fb_in      (fb_in),
    .edge_count (edge_count),
    .freq_err   (freq_err),
    .meas_valid (meas_valid),
    .locked     (locked)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: constant low; mode 1: high only on the last window cycle; else square wave of that period
  function automatic logic fb_pat(input int mode, input int k);
    if (mode == 0) return 1'b0;
    if (mode == 1) return (k == 255);
    return ((k % mode) < (mode / 2));
  endfunction

  task automatic run_cycles(input int mode, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      fb_in = fb_pat(mode, k);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_window(input int mode, input int exp_cnt, input int exp_err,
                            input logic exp_lock, input string tag);
    for (int k = 0; k < 256; k++) begin
      fb_in = fb_pat(mode, k);
      @(posedge clk); #1;
      if (k == 0)   check({tag, ".mv_k0"}, meas_valid, 0);
      if (k == 254) check({tag, ".mv_k254"}, meas_valid, 0);
    end
    check({tag, ".mv"},     meas_valid, 1);
    check({tag, ".count"},  edge_count, exp_cnt);
    check({tag, ".err"},    freq_err,   exp_err);
    check({tag, ".locked"}, locked,     exp_lock);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    fb_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.count",  edge_count, 0);
    check("rst.err",    freq_err,   0);
    check("rst.mv",     meas_valid, 0);
    check("rst.locked", locked,     0);
    rst = 1'b0;

    // Period 10 aligned to window start: rises at k=0,10,..,250 -> 26 per window
    run_window(10, 26, 1, 1'b0, "t1w1");
    run_window(10, 26, 1, 1'b0, "t1w2");
    run_window(10, 26, 1, 1'b0, "t1w3");
    run_window(10, 26, 1, 1'b1, "t1w4");

    // Period 8: rises at k=0,8,..,248 -> 32, error +7
    run_window(8, 32, 7, 1'b1, "t2w1");
    run_window(8, 32, 7, 1'b0, "t2w2");

    run_window(0, 0, -25, 1'b0, "t3low1");
    run_window(0, 0, -25, 1'b0, "t3low2");
    run_window(0, 0, -25, 1'b0, "t3low3");
    run_window(10, 26, 1, 1'b0, "t3rl1");
    run_window(10, 26, 1, 1'b0, "t3rl2");
    run_window(10, 26, 1, 1'b0, "t3rl3");
    run_window(10, 26, 1, 1'b1, "t3rl4");

    // Alternating bad/good while locked never reaches two consecutive bad windows
    run_window(8,  32, 7, 1'b1, "t4b1");
    run_window(10, 26, 1, 1'b1, "t4g1");
    run_window(8,  32, 7, 1'b1, "t4b2");
    run_window(10, 26, 1, 1'b1, "t4g2");
    run_window(8,  32, 7, 1'b1, "t4b3");
    run_window(10, 26, 1, 1'b1, "t4g3");

    // Reset applied on the wc=100 cycle
    run_cycles(10, 0, 100);
    rst   = 1'b1;
    fb_in = fb_pat(10, 100);
    @(posedge clk); #1;
    check("t5.rst.count",  edge_count, 0);
    check("t5.rst.err",    freq_err,   0);
    check("t5.rst.mv",     meas_valid, 0);
    check("t5.rst.locked", locked,     0);
    rst = 1'b0;
    run_window(10, 26, 1, 1'b0, "t5w1");
    run_window(10, 26, 1, 1'b0, "t5w2");
    run_window(10, 26, 1, 1'b0, "t5w3");
    run_window(10, 26, 1, 1'b1, "t5w4");

    // en dropped mid-window: lock lost, results held
    run_cycles(10, 0, 50);
    en    = 1'b0;
    fb_in = fb_pat(10, 50);
    @(posedge clk); #1;
    check("t6off.locked", locked,     0);
    check("t6off.count",  edge_count, 26);
    check("t6off.err",    freq_err,   1);
    check("t6off.mv",     meas_valid, 0);
    run_cycles(10, 51, 20);
    check("t6hold.count",  edge_count, 26);
    check("t6hold.locked", locked,     0);
    check("t6hold.mv",     meas_valid, 0);
    // fb was high on the last disabled cycle, so k=0 is not a rise -> 25
    en = 1'b1;
    run_window(10, 25, 0, 1'b0, "t6re");

    // Single rise on the closing cycle counts in that window only
    run_window(1, 1, -24, 1'b0, "t6edge");
    run_window(0, 0, -25, 1'b0, "t6next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_freq_lock_detector.md
Name: fb_freq_lock_detector

Overview:
Measures the divided feedback clock produced by the PLL feedback divider, treated as a data signal sampled in the clk domain. It counts rising edges of that signal over a fixed window of clk cycles and compares the count with an expected value. A hysteresis FSM then declares or drops frequency lock. The block sits at the consuming end of the divider output, beside the phase detector, and drives the SERDES lock/ready status.

Parameters:
WINDOW_LOG2, 8, measurement window = 2^WINDOW_LOG2 clk cycles
EXPECTED, 25, nominal fb rising edges per window
TOL, 1, allowed absolute deviation |count-EXPECTED| for a "good" window
LOCK_COUNT, 4, consecutive good windows needed to assert locked (>=1)
UNLOCK_COUNT, 2, consecutive bad windows needed to drop locked (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  measurement enable
fb_in  in  1  divided feedback signal
edge_count  out  WINDOW_LOG2  rising-edge count of last completed window
freq_err  out  WINDOW_LOG2+1  signed, edge_count-EXPECTED, two's complement
meas_valid  out  1  one-cycle pulse: edge_count/freq_err updated
locked  out  1  frequency lock status

Behaviour:
- Reset (rst=1, clk edge): window counter=0, accumulator=0, edge_count=0, freq_err=0, meas_valid=0, locked=0, FSM=UNLOCKED, good/bad counters=0. Reset mid-window discards the partial count; the next window starts the cycle after rst falls.
- Edge detect: rise = fb_s & ~fb_q, where fb_q = fb_s delayed one clk. fb_s = fb_in (or the synchronised version, see Optional Feature). The first cycle after reset cannot produce a rise; fb_q resets to 0.
- Window: counter wc runs 0..2^WINDOW_LOG2-1 while en=1, then wraps to 0.
- Accumulator: adds rise each cycle. It saturates at 2^WINDOW_LOG2-1 and never wraps.
- Window close (wc==max): edge_count <= acc+rise, saturated. A rise on the closing cycle counts in the closing window. acc <= 0. freq_err <= that value - EXPECTED. meas_valid = 1 in the following cycle only.
- Window classification: good if |count-EXPECTED| <= TOL, else bad. Evaluated on the same clk edge that loads edge_count, so locked changes in the same cycle meas_valid is high.
- FSM states and transitions:
  UNLOCKED (locked=0): good -> ACQUIRE with good_cnt=1; if LOCK_COUNT==1, go straight to LOCKED.
  ACQUIRE (locked=0): good -> good_cnt++, reaching LOCK_COUNT -> LOCKED; bad -> UNLOCKED, good_cnt=0.
  LOCKED (locked=1): good -> stay; bad -> HOLD with bad_cnt=1; if UNLOCK_COUNT==1, go straight to UNLOCKED.
  HOLD (locked=1): good -> LOCKED, bad_cnt=0; bad -> bad_cnt++, reaching UNLOCK_COUNT -> UNLOCKED.
- en=0: wc, acc, good_cnt and bad_cnt cleared; FSM -> UNLOCKED; locked=0; meas_valid=0; edge_count and freq_err hold. Re-enabling starts a fresh full window.
- fb stuck high or low: count=0, window bad.

Optional Feature:
FB_INPUT_SYNC_EN
- Defined: fb_in passes through a 2-flop synchroniser (reset to 0) before edge detect. Edge-to-count latency grows by 2 clk.
- Undefined: fb_in is used directly and must be synchronous to clk.
- Window boundaries and FSM behaviour are otherwise identical.

Decomposition:
- Package fld_pkg: FSM state enum (UNLOCKED, ACQUIRE, LOCKED, HOLD) and a window-classification helper function (good/bad from count, EXPECTED, TOL).
- Sub-module fld_window_meter: edge detect, window counter, saturating accumulator, edge_count/freq_err/meas_valid.
- Top level: the optional synchroniser and the lock FSM.

Test Plan:
1. Defaults, fb period 10 clk, en=1 -> each meas_valid shows edge_count 25 or 26 and freq_err 0/+1; locked rises with the 4th meas_valid pulse.
2. After lock, switch fb to period 8 clk -> edge_count 32, freq_err +7; locked stays 1 after the 1st bad window and falls with the 2nd.
3. fb held 0 for 3 windows -> edge_count 0, freq_err -25, locked 0; then period 10 resumes -> relock after exactly 4 windows.
4. Alternating good/bad windows while LOCKED (HOLD <-> LOCKED) -> locked remains 1; one good window between two bad ones resets bad_cnt.
5. rst pulsed at wc=100 while locked -> all outputs 0 next cycle; first meas_valid exactly 256 cycles after rst falls.
6. fb rise placed exactly on the wc=255 cycle -> counted in the closing window, not the next one; en dropped mid-window -> locked 0, edge_count held.
